viterbi_puncture: RTL and testbench

- Transmit-side puncturer placed after viterbi_enc.
- Takes the rate-1/2 encoder symbols, deletes bits according to a puncturing pattern, and repacks the surviving bits into a dense 2-bit output stream.
- Its output is what viterbi_speed_map de-punctures on the receive side, and both blocks use the same pattern parameters.
- The block supports per-frame rate selection, an end-of-frame flush of an odd leftover bit, and a per-bit valid mask on the output.

---
 rtl/viterbi_puncture_pkg.sv | 31 +++
 rtl/viterbi_punct_pattern.sv | 41 ++++
 rtl/viterbi_puncture.sv | 123 ++++++++++++
 tb/tb_viterbi_puncture.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/viterbi_puncture_pkg.sv
// rtl/viterbi_puncture_pkg.sv - shared speed codes, rate-2/3 masks and state encoding
// Shared with viterbi_speed_map so both ends of the link agree on codes and patterns.
package viterbi_puncture_pkg;

  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    SPD_R12  = 2'd0,
    SPD_R23  = 2'd1,
    SPD_PROG = 2'd2
  } spd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] R23_POL0 = 2'b11;
  localparam logic [1:0] R23_POL1 = 2'b01;

  // The reserved code 3 behaves as plain rate 1/2.
  function automatic spd_e spd_decode(input logic [1:0] code);
    case (code)
      2'd1:    spd_decode = SPD_R23;
      2'd2:    spd_decode = SPD_PROG;
      default: spd_decode = SPD_R12;
    endcase
  endfunction

endpackage

// File: rtl/viterbi_punct_pattern.sv
// rtl/viterbi_punct_pattern.sv - combinational keep-mask and wrap lookup
// Returns {keep1, keep0} for the current pattern index and flags the last index of the period.
module viterbi_punct_pattern
  import viterbi_puncture_pkg::*;
#(
  parameter int                      p_speed_size = 3,
  parameter logic [p_speed_size-1:0] p_speed_pol0 = 3'b101,
  parameter logic [p_speed_size-1:0] p_speed_pol1 = 3'b011
) (
  input  spd_e             i_spd,
  input  logic [IDX_W-1:0] i_idx,
  output logic [1:0]       o_keep,
  output logic             o_wrap
);

  logic [7:0] w_pol0;
  logic [7:0] w_pol1;

  assign w_pol0 = 8'(p_speed_pol0);
  assign w_pol1 = 8'(p_speed_pol1);

  always_comb begin
    o_keep = 2'b11;
    o_wrap = 1'b1;
    case (i_spd)
      SPD_R23: begin
        o_keep = {R23_POL1[i_idx[0]], R23_POL0[i_idx[0]]};
        o_wrap = (i_idx == 3'd1);
      end
      SPD_PROG: begin
        o_keep = {w_pol1[i_idx], w_pol0[i_idx]};
        o_wrap = (i_idx == 3'(p_speed_size - 1));
      end
      default: begin
        o_keep = 2'b11;
        o_wrap = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/viterbi_puncture.sv
// rtl/viterbi_puncture.sv - transmit puncturer repacking kept encoder bits into 2-bit words
// Holds at most one leftover bit between symbols; an odd leftover is flushed at end of frame.
module viterbi_puncture
  import viterbi_puncture_pkg::*;
#(
  parameter int                      p_speed_size = 3,
  parameter logic [p_speed_size-1:0] p_speed_pol0 = 3'b101,
  parameter logic [p_speed_size-1:0] p_speed_pol1 = 3'b011
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_data,
  input  logic       i_valid,
  input  logic       i_last,
  input  logic [1:0] i_speed,
  output logic [1:0] o_data,
  output logic [1:0] o_valid,
  output logic       o_busy
);

  state_e           r_state;
  state_e           w_state_nxt;
  spd_e             r_spd;
  spd_e             w_spd_cur;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_cur;
  logic             r_acc;
  logic             r_cnt;
  logic [1:0]       r_data;
  logic [1:0]       r_valid;
  logic             w_proc;
  logic             w_flush;
  logic [1:0]       w_keep;
  logic             w_wrap;
  logic [2:0]       w_bits;
  logic [1:0]       w_n;
  logic             w_full;

  // The first symbol of a frame uses the live rate and index 0; later ones use the latched rate.
  assign w_spd_cur = (r_state == ST_IDLE) ? spd_decode(i_speed) : r_spd;
  assign w_idx_cur = (r_state == ST_IDLE) ? '0 : r_idx;

  viterbi_punct_pattern #(
    .p_speed_size(p_speed_size),
    .p_speed_pol0(p_speed_pol0),
    .p_speed_pol1(p_speed_pol1)
  ) u_pattern (
    .i_spd (w_spd_cur),
    .i_idx (w_idx_cur),
    .o_keep(w_keep),
    .o_wrap(w_wrap)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_proc      = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (i_valid) begin
          w_proc      = 1'b1;
          w_state_nxt = i_last ? ST_FLUSH : ST_RUN;
        end
      end
      ST_FLUSH: begin
        w_flush     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Stream-order append: w_bits[0] is the oldest bit.
  always_comb begin
    w_bits = {2'b00, r_acc & r_cnt};
    w_n    = {1'b0, r_cnt};
    if (w_keep[0]) begin
      w_bits[w_n] = i_data[0];
      w_n         = w_n + 2'd1;
    end
    if (w_keep[1]) begin
      w_bits[w_n] = i_data[1];
      w_n         = w_n + 2'd1;
    end
    w_full = (w_n >= 2'd2);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_spd   <= SPD_R12;
      r_idx   <= '0;
      r_acc   <= 1'b0;
      r_cnt   <= 1'b0;
      r_data  <= 2'b00;
      r_valid <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      if (w_proc) begin
        r_spd   <= w_spd_cur;
        r_idx   <= w_wrap ? '0 : w_idx_cur + 3'd1;
        r_data  <= w_full ? w_bits[1:0] : 2'b00;
        r_valid <= w_full ? 2'b11 : 2'b00;
        r_acc   <= w_full ? w_bits[2] : w_bits[0];
        r_cnt   <= w_full ? (w_n == 2'd3) : (w_n == 2'd1);
      end else if (w_flush) begin
        r_data  <= {1'b0, r_acc & r_cnt};
        r_valid <= r_cnt ? 2'b01 : 2'b00;
        r_idx   <= '0;
        r_acc   <= 1'b0;
        r_cnt   <= 1'b0;
      end else begin
        r_data  <= 2'b00;
        r_valid <= 2'b00;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_busy  = (r_state != ST_IDLE) | (|r_valid);

endmodule

// File: tb/tb_viterbi_puncture.sv
// tb/tb_viterbi_puncture.sv - directed vector bench for viterbi_puncture
module tb_viterbi_puncture;

  logic       i_clk;
  logic       i_reset;
  logic [1:0] i_data;
  logic       i_valid;
  logic       i_last;
  logic [1:0] i_speed;
  logic [1:0] o_data;
  logic [1:0] o_valid;
  logic       o_busy;

  int checks;
  int failures;

  viterbi_puncture dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_data (i_data),
    .i_valid(i_valid),
    .i_last (i_last),
    .i_speed(i_speed),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_busy (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       v;
    logic       l;
    logic [1:0] spd;
    logic [1:0] d;
    logic [1:0] ev;
    logic [1:0] ed;
    logic       eb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic l, input logic [1:0] spd, input logic [1:0] d,
                     input logic [1:0] ev, input logic [1:0] ed, input logic eb);
    vec_t t;
    t.v = v; t.l = l; t.spd = spd; t.d = d; t.ev = ev; t.ed = ed; t.eb = eb;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [1:0] spd, input logic [1:0] d);
    @(negedge i_clk);
    i_valid = v; i_last = l; i_speed = spd; i_data = d;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    i_reset  = 1'b0;
    i_data   = 2'b00;
    i_valid  = 1'b0;
    i_last   = 1'b0;
    i_speed  = 2'd0;

    // rate 1/2, with a symbol offered during FLUSH that must be ignored
    add(1'b1, 1'b0, 2'd0, 2'b10, 2'b11, 2'b10, 1'b1);
    add(1'b1, 1'b0, 2'd0, 2'b01, 2'b11, 2'b01, 1'b1);
    add(1'b1, 1'b1, 2'd0, 2'b11, 2'b11, 2'b11, 1'b1);
    add(1'b1, 1'b0, 2'd0, 2'b11, 2'b00, 2'b00, 1'b0);
    add(1'b0, 1'b0, 2'd0, 2'b00, 2'b00, 2'b00, 1'b0);
    // programmable pattern, 4 bits from 3 symbols
    add(1'b1, 1'b0, 2'd2, 2'b10, 2'b11, 2'b10, 1'b1);
    add(1'b1, 1'b0, 2'd2, 2'b01, 2'b00, 2'b00, 1'b1);
    add(1'b1, 1'b1, 2'd2, 2'b11, 2'b11, 2'b10, 1'b1);
    add(1'b0, 1'b0, 2'd2, 2'b00, 2'b00, 2'b00, 1'b0);
    // odd flush
    add(1'b1, 1'b0, 2'd2, 2'b11, 2'b11, 2'b11, 1'b1);
    add(1'b1, 1'b1, 2'd2, 2'b10, 2'b00, 2'b00, 1'b1);
    add(1'b0, 1'b0, 2'd2, 2'b00, 2'b01, 2'b01, 1'b1);
    add(1'b0, 1'b0, 2'd2, 2'b00, 2'b00, 2'b00, 1'b0);
    // rate 2/3 with a gap and i_speed changed mid-frame
    add(1'b1, 1'b0, 2'd1, 2'b01, 2'b11, 2'b01, 1'b1);
    add(1'b0, 1'b0, 2'd0, 2'b00, 2'b00, 2'b00, 1'b1);
    add(1'b1, 1'b0, 2'd0, 2'b11, 2'b00, 2'b00, 1'b1);
    add(1'b1, 1'b0, 2'd0, 2'b10, 2'b11, 2'b01, 1'b1);
    add(1'b1, 1'b1, 2'd0, 2'b11, 2'b11, 2'b11, 1'b1);
    add(1'b0, 1'b0, 2'd0, 2'b00, 2'b00, 2'b00, 1'b0);
    // reserved speed code acts as rate 1/2
    add(1'b1, 1'b1, 2'd3, 2'b10, 2'b11, 2'b10, 1'b1);
    add(1'b0, 1'b0, 2'd3, 2'b00, 2'b00, 2'b00, 1'b0);
    // programmable pattern wrapping back to index 0
    add(1'b1, 1'b0, 2'd2, 2'b10, 2'b11, 2'b10, 1'b1);
    add(1'b1, 1'b0, 2'd2, 2'b01, 2'b00, 2'b00, 1'b1);
    add(1'b1, 1'b0, 2'd2, 2'b11, 2'b11, 2'b10, 1'b1);
    add(1'b1, 1'b1, 2'd2, 2'b01, 2'b11, 2'b01, 1'b1);
    add(1'b0, 1'b0, 2'd2, 2'b00, 2'b00, 2'b00, 1'b0);

    #12;
    check("reset_valid", o_valid, 2'b00);
    check("reset_data", o_data, 2'b00);
    check("reset_busy", {1'b0, o_busy}, 2'b00);
    @(negedge i_clk);
    i_reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].l, vecs[i].spd, vecs[i].d);
      check($sformatf("vec%0d_valid", i), o_valid, vecs[i].ev);
      if (vecs[i].ev != 2'b00)
        check($sformatf("vec%0d_data", i), o_data, vecs[i].ed);
      check($sformatf("vec%0d_busy", i), {1'b0, o_busy}, {1'b0, vecs[i].eb});
    end

    // reset mid-frame while a bit is held and a word is on the output
    drive(1'b1, 1'b0, 2'd1, 2'b11);
    drive(1'b1, 1'b0, 2'd1, 2'b01);
    drive(1'b1, 1'b0, 2'd1, 2'b11);
    check("pre_reset_valid", o_valid, 2'b11);
    #2;
    i_reset = 1'b0;
    i_valid = 1'b0;
    #1;
    check("async_reset_valid", o_valid, 2'b00);
    check("async_reset_busy", {1'b0, o_busy}, 2'b00);
    @(negedge i_clk);
    i_reset = 1'b1;
    drive(1'b1, 1'b1, 2'd2, 2'b10);
    check("post_reset_valid", o_valid, 2'b11);
    check("post_reset_data", o_data, 2'b10);
    drive(1'b0, 1'b0, 2'd2, 2'b00);
    check("post_reset_flush_valid", o_valid, 2'b00);
    check("post_reset_flush_busy", {1'b0, o_busy}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
